// File: rtl/util_avl2fifo_sched.sv
// Write scheduler for the TX Avalon-to-FIFO adapter: paces write enables at a
// fractional num/den rate and marks the first write of every frame with a sync strobe.
module util_avl2fifo_sched #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctrl_start,
    input  logic                 ctrl_stop,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [7:0]           cfg_num,
    input  logic [7:0]           cfg_den,
    input  logic                 fifo_wr_ready,
    output logic                 fifo_wr_en,
    output logic                 fifo_wr_sync,
    input  logic                 stat_clr,
    output logic [1:0]           stat_state,
    output logic                 stat_busy,
    output logic [15:0]          stat_frame_cnt,
    output logic                 stat_uflow,
    output logic [7:0]           stat_uflow_cnt,
    output logic                 stat_cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [7:0]           num_q, num_d;
    logic [7:0]           den_q, den_d;
    logic [7:0]           acc_q, acc_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_sync_q, wr_sync_d;
    logic                 uflow_q, uflow_d;
    logic [7:0]           uflow_cnt_q, uflow_cnt_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [8:0] sum;
    logic       write_due;
    logic       last_write;
    logic       cfg_ok;
    logic       cfg_err_set;
    logic       uflow_evt;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        wcnt_d      = wcnt_q;
        num_d       = num_q;
        den_d       = den_q;
        acc_d       = acc_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = 1'b0;
        wr_sync_d   = 1'b0;
        uflow_d     = uflow_q;
        uflow_cnt_d = uflow_cnt_q;
        cfg_err_d   = cfg_err_q;
        cfg_err_set = 1'b0;

        // acc < den always holds, so the sum fits in 9 bits and s-den fits in 8
        sum        = {1'b0, acc_q} + {1'b0, num_q};
        write_due  = (sum >= {1'b0, den_q});
        last_write = (wcnt_q == period_q - CNT_WIDTH'(1));
        cfg_ok     = (cfg_period != '0) && (cfg_num != 8'd0) && (cfg_num <= cfg_den);
        uflow_evt  = wr_en_q & ~fifo_wr_ready;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_start && !ctrl_stop) begin
                    if (cfg_ok) begin
                        period_d    = cfg_period;
                        num_d       = cfg_num;
                        den_d       = cfg_den;
                        acc_d       = cfg_den - cfg_num;
                        wcnt_d      = '0;
                        frame_cnt_d = 16'd0;
                        state_d     = ST_ARM;
                    end else begin
                        cfg_err_set = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (ctrl_stop) begin
                    state_d = ST_IDLE;
                end else if (fifo_wr_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (write_due) begin
                    acc_d     = sum[7:0] - den_q;
                    wr_en_d   = 1'b1;
                    wr_sync_d = (wcnt_q == '0);
                    if (last_write) begin
                        wcnt_d      = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        wcnt_d = wcnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    acc_d = sum[7:0];
                end

                // Leave only on a frame boundary: either already there or closing it now
                if (state_q == ST_RUN) begin
                    if (ctrl_stop) begin
                        if ((!write_due && wcnt_q == '0) || (write_due && last_write)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end else if (write_due && last_write) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (cfg_err_set) begin
            cfg_err_d = 1'b1;
        end else if (stat_clr) begin
            cfg_err_d = 1'b0;
        end

        if (uflow_evt) begin
            uflow_d = 1'b1;
            if (stat_clr) begin
                uflow_cnt_d = 8'd1;
            end else if (uflow_cnt_q != 8'hFF) begin
                uflow_cnt_d = uflow_cnt_q + 8'd1;
            end
        end else if (stat_clr) begin
            uflow_d     = 1'b0;
            uflow_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            period_q    <= '0;
            wcnt_q      <= '0;
            num_q       <= 8'd0;
            den_q       <= 8'd0;
            acc_q       <= 8'd0;
            frame_cnt_q <= 16'd0;
            wr_en_q     <= 1'b0;
            wr_sync_q   <= 1'b0;
            uflow_q     <= 1'b0;
            uflow_cnt_q <= 8'd0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            wcnt_q      <= wcnt_d;
            num_q       <= num_d;
            den_q       <= den_d;
            acc_q       <= acc_d;
            frame_cnt_q <= frame_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_sync_q   <= wr_sync_d;
            uflow_q     <= uflow_d;
            uflow_cnt_q <= uflow_cnt_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign fifo_wr_en     = wr_en_q;
    assign fifo_wr_sync   = wr_sync_q;
    assign stat_state     = state_q;
    assign stat_busy      = (state_q != ST_IDLE);
    assign stat_frame_cnt = frame_cnt_q;
    assign stat_uflow     = uflow_q;
    assign stat_uflow_cnt = uflow_cnt_q;
    assign stat_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_util_avl2fifo_sched.sv
// Directed bench for util_avl2fifo_sched: a per-cycle vector table for the 1/2-rate
// run-and-drain case plus hand sequences for stop, arm, underflow, config and reset corners.
module tb_util_avl2fifo_sched;

    logic        clk;
    logic        rst_n;
    logic        ctrl_start;
    logic        ctrl_stop;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_num;
    logic [7:0]  cfg_den;
    logic        fifo_wr_ready;
    logic        fifo_wr_en;
    logic        fifo_wr_sync;
    logic        stat_clr;
    logic [1:0]  stat_state;
    logic        stat_busy;
    logic [15:0] stat_frame_cnt;
    logic        stat_uflow;
    logic [7:0]  stat_uflow_cnt;
    logic        stat_cfg_err;

    util_avl2fifo_sched #(.CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_start    (ctrl_start),
        .ctrl_stop     (ctrl_stop),
        .cfg_period    (cfg_period),
        .cfg_num       (cfg_num),
        .cfg_den       (cfg_den),
        .fifo_wr_ready (fifo_wr_ready),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_sync  (fifo_wr_sync),
        .stat_clr      (stat_clr),
        .stat_state    (stat_state),
        .stat_busy     (stat_busy),
        .stat_frame_cnt(stat_frame_cnt),
        .stat_uflow    (stat_uflow),
        .stat_uflow_cnt(stat_uflow_cnt),
        .stat_cfg_err  (stat_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic        ready;
        logic [1:0]  exp_state;
        logic        exp_en;
        logic        exp_sync;
        logic [15:0] exp_frame;
    } vec_t;

    localparam int NUM_VECS = 26;
    vec_t vecs [NUM_VECS];

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int wr_total;
    int sync_total;
    logic last_sync;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic ready, input logic clr);
        ctrl_start    = start;
        ctrl_stop     = stop;
        fifo_wr_ready = ready;
        stat_clr      = clr;
    endtask

    task automatic setCfg(input logic [15:0] period, input logic [7:0] num, input logic [7:0] den);
        cfg_period = period;
        cfg_num    = num;
        cfg_den    = den;
    endtask

    // Advance one clock and sample 1 time unit after the edge; tallies writes seen
    task automatic tick();
        @(posedge clk);
        #1;
        if (fifo_wr_en) begin
            wr_total++;
            last_sync = fifo_wr_sync;
        end
        if (fifo_wr_sync) sync_total++;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wr_total   = 0;
        sync_total = 0;
        last_sync  = 1'b0;
    endtask

    task automatic setVec(input int idx, input logic start, input logic stop, input logic [1:0] st,
                          input logic en, input logic sync, input logic [15:0] frame);
        vecs[idx].start     = start;
        vecs[idx].stop      = stop;
        vecs[idx].ready     = 1'b1;
        vecs[idx].exp_state = st;
        vecs[idx].exp_en    = en;
        vecs[idx].exp_sync  = sync;
        vecs[idx].exp_frame = frame;
    endtask

    task automatic runTable(input string tag);
        setCfg(16'd4, 8'd1, 8'd2);
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].ready, 1'b0);
            tick();
            checkOutput($sformatf("%s[%0d].state", tag, i), 32'(stat_state), 32'(vecs[i].exp_state));
            checkOutput($sformatf("%s[%0d].en", tag, i), 32'(fifo_wr_en), 32'(vecs[i].exp_en));
            checkOutput($sformatf("%s[%0d].sync", tag, i), 32'(fifo_wr_sync), 32'(vecs[i].exp_sync));
            checkOutput($sformatf("%s[%0d].frame", tag, i), 32'(stat_frame_cnt), 32'(vecs[i].exp_frame));
        end
        checkOutput({tag, ".uflow"}, 32'(stat_uflow), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // period=4 at 1/2: writes every other RUN cycle, sync every 4th write,
        // stop at wcnt=1 drains writes 1..3 of the frame and then returns to IDLE
        setVec( 0, 1, 0, 2'd1, 0, 0, 16'd0);
        setVec( 1, 0, 0, 2'd2, 0, 0, 16'd0);
        setVec( 2, 0, 0, 2'd2, 1, 1, 16'd0);
        setVec( 3, 0, 0, 2'd2, 0, 0, 16'd0);
        setVec( 4, 0, 0, 2'd2, 1, 0, 16'd0);
        setVec( 5, 0, 0, 2'd2, 0, 0, 16'd0);
        setVec( 6, 0, 0, 2'd2, 1, 0, 16'd0);
        setVec( 7, 0, 0, 2'd2, 0, 0, 16'd0);
        setVec( 8, 0, 0, 2'd2, 1, 0, 16'd1);
        setVec( 9, 0, 0, 2'd2, 0, 0, 16'd1);
        setVec(10, 0, 0, 2'd2, 1, 1, 16'd1);
        setVec(11, 0, 0, 2'd2, 0, 0, 16'd1);
        setVec(12, 0, 0, 2'd2, 1, 0, 16'd1);
        setVec(13, 0, 0, 2'd2, 0, 0, 16'd1);
        setVec(14, 0, 0, 2'd2, 1, 0, 16'd1);
        setVec(15, 0, 0, 2'd2, 0, 0, 16'd1);
        setVec(16, 0, 0, 2'd2, 1, 0, 16'd2);
        setVec(17, 0, 0, 2'd2, 0, 0, 16'd2);
        setVec(18, 0, 0, 2'd2, 1, 1, 16'd2);
        setVec(19, 0, 1, 2'd3, 0, 0, 16'd2);
        setVec(20, 0, 0, 2'd3, 1, 0, 16'd2);
        setVec(21, 0, 0, 2'd3, 0, 0, 16'd2);
        setVec(22, 0, 0, 2'd3, 1, 0, 16'd2);
        setVec(23, 0, 0, 2'd3, 0, 0, 16'd2);
        setVec(24, 0, 0, 2'd0, 1, 0, 16'd3);
        setVec(25, 0, 0, 2'd0, 0, 0, 16'd3);

        setCfg(16'd4, 8'd1, 8'd2);
        doReset();
        checkOutput("rst.en", 32'(fifo_wr_en), 32'd0);
        checkOutput("rst.sync", 32'(fifo_wr_sync), 32'd0);
        checkOutput("rst.state", 32'(stat_state), 32'd0);
        checkOutput("rst.busy", 32'(stat_busy), 32'd0);
        checkOutput("rst.frame", 32'(stat_frame_cnt), 32'd0);
        checkOutput("rst.uflow_cnt", 32'(stat_uflow_cnt), 32'd0);
        checkOutput("rst.cfg_err", 32'(stat_cfg_err), 32'd0);

        runTable("run12");

        // Full rate, period 5: stop seen while wcnt=2 leaves writes 2,3,4 to go
        doReset();
        setCfg(16'd5, 8'd3, 8'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("full.run", 32'(stat_state), 32'd2);
        tick();
        checkOutput("full.first_sync", 32'(fifo_wr_sync), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("full.drain", 32'(stat_state), 32'd3);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("full.total_writes", 32'(wr_total), 32'd5);
        checkOutput("full.syncs", 32'(sync_total), 32'd1);
        checkOutput("full.last_sync", 32'(last_sync), 32'd0);
        checkOutput("full.idle", 32'(stat_state), 32'd0);
        checkOutput("full.busy", 32'(stat_busy), 32'd0);
        checkOutput("full.frames", 32'(stat_frame_cnt), 32'd1);

        // Arm waits without ready, stop aborts; then ready arrives late
        doReset();
        setCfg(16'd4, 8'd1, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("arm.state", 32'(stat_state), 32'd1);
        checkOutput("arm.busy", 32'(stat_busy), 32'd1);
        checkOutput("arm.no_writes", 32'(wr_total), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("arm.abort", 32'(stat_state), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("late.run", 32'(stat_state), 32'd2);
        checkOutput("late.en0", 32'(fifo_wr_en), 32'd0);
        tick();
        checkOutput("late.en", 32'(fifo_wr_en), 32'd1);
        checkOutput("late.sync", 32'(fifo_wr_sync), 32'd1);

        // Period 1 at 1/2: every write closes a frame, so stop on an idle cycle exits at once
        doReset();
        setCfg(16'd1, 8'd1, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("p1.en", 32'(fifo_wr_en), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("p1.direct_idle", 32'(stat_state), 32'd0);
        checkOutput("p1.en_off", 32'(fifo_wr_en), 32'd0);
        checkOutput("p1.frames", 32'(stat_frame_cnt), 32'd1);

        // Underflow at 1/1, clear racing an event, then saturation
        doReset();
        setCfg(16'd4, 8'd1, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("uf.en", 32'(fifo_wr_en), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("uf.flag", 32'(stat_uflow), 32'd1);
        checkOutput("uf.cnt3", 32'(stat_uflow_cnt), 32'd3);
        checkOutput("uf.still_writing", 32'(fifo_wr_en), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("uf.clr_race_flag", 32'(stat_uflow), 32'd1);
        checkOutput("uf.clr_race_cnt", 32'(stat_uflow_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("uf.clr_flag", 32'(stat_uflow), 32'd0);
        checkOutput("uf.clr_cnt", 32'(stat_uflow_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) tick();
        checkOutput("uf.sat_cnt", 32'(stat_uflow_cnt), 32'd255);
        checkOutput("uf.sat_flag", 32'(stat_uflow), 32'd1);
        checkOutput("uf.sat_state", 32'(stat_state), 32'd2);

        // Configuration rejection and start/stop collision
        doReset();
        setCfg(16'd4, 8'd5, 8'd4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("cfg.num_gt_den_err", 32'(stat_cfg_err), 32'd1);
        checkOutput("cfg.num_gt_den_state", 32'(stat_state), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("cfg.clr", 32'(stat_cfg_err), 32'd0);
        setCfg(16'd0, 8'd1, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("cfg.period0_err", 32'(stat_cfg_err), 32'd1);
        checkOutput("cfg.period0_state", 32'(stat_state), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        setCfg(16'd4, 8'd1, 8'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("cfg.start_stop_state", 32'(stat_state), 32'd0);
        checkOutput("cfg.start_stop_err", 32'(stat_cfg_err), 32'd0);

        // Asynchronous reset in the middle of a frame
        doReset();
        setCfg(16'd4, 8'd0, 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        setCfg(16'd4, 8'd1, 8'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("amr.pre_frame", 32'(stat_frame_cnt), 32'd1);
        checkOutput("amr.pre_uflow", 32'(stat_uflow), 32'd1);
        checkOutput("amr.pre_err", 32'(stat_cfg_err), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("amr.pre_en", 32'(fifo_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("amr.en", 32'(fifo_wr_en), 32'd0);
        checkOutput("amr.sync", 32'(fifo_wr_sync), 32'd0);
        checkOutput("amr.state", 32'(stat_state), 32'd0);
        checkOutput("amr.busy", 32'(stat_busy), 32'd0);
        checkOutput("amr.frame", 32'(stat_frame_cnt), 32'd0);
        checkOutput("amr.uflow", 32'(stat_uflow), 32'd0);
        checkOutput("amr.uflow_cnt", 32'(stat_uflow_cnt), 32'd0);
        checkOutput("amr.cfg_err", 32'(stat_cfg_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        runTable("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
